// File: rtl/tx_frame_scheduler_if.sv
// Handshake bundle between the frame sources, the MII transmit engine and tx_frame_scheduler.
// master = scheduler side, slave = sources / transmit-engine side.
interface tx_frame_scheduler_if;
  logic data_req;
  logic ctrl_req;
  logic data_ack;
  logic ctrl_ack;
  logic tx_start;
  logic tx_sel;
  logic phy_txen;

  modport master (
    input  data_req, ctrl_req, phy_txen,
    output data_ack, ctrl_ack, tx_start, tx_sel
  );

  modport slave (
    output data_req, ctrl_req, phy_txen,
    input  data_ack, ctrl_ack, tx_start, tx_sel
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Shares the MII transmit engine between data frames and need-data control frames, enforcing the IFG.
// Optional macro TX_SCHED_CTRL_PRIORITY_EN: control requests win strictly instead of round-robin.
module tx_frame_scheduler #(
  parameter int IFG_NIBBLES = 24,
  parameter int MAX_WAIT    = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 phy_txclk,
  input  logic                 reset,
  input  logic                 enable,
  tx_frame_scheduler_if.master bus,
  output logic                 sched_busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     ctrl_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_IFG    = 3'd4;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int GAP_W  = $clog2(IFG_NIBBLES + 1);
  // The wait counter fires on the edge where it would step to MAX_WAIT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 2);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(IFG_NIBBLES - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              tx_sel_q, tx_sel_d;
  logic              last_sel_q, last_sel_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]  ctrl_cnt_q, ctrl_cnt_d;
  logic              pick_ctrl;

  always_comb begin
`ifdef TX_SCHED_CTRL_PRIORITY_EN
    pick_ctrl = bus.ctrl_req;
`else
    pick_ctrl = bus.ctrl_req & (~bus.data_req | ~last_sel_q);
`endif
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    tx_sel_d    = tx_sel_q;
    last_sel_d  = last_sel_q;
    timeout_d   = timeout_q;
    frame_cnt_d = frame_cnt_q;
    ctrl_cnt_d  = ctrl_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable && (bus.data_req || bus.ctrl_req)) begin
          state_d    = S_START;
          tx_sel_d   = pick_ctrl;
          last_sel_d = pick_ctrl;
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.phy_txen) begin
          state_d = S_ACTIVE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          gap_cnt_d = '0;
          state_d   = S_IFG;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_ACTIVE: begin
        if (!bus.phy_txen) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          if (tx_sel_q) ctrl_cnt_d = ctrl_cnt_q + CNT_W'(1);
          gap_cnt_d = '0;
          state_d   = S_IFG;
        end
      end
      S_IFG: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transmit engine launches on the falling edge, so the scheduler does too.
  always_ff @(negedge phy_txclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      tx_sel_q    <= 1'b0;
      last_sel_q  <= 1'b1;
      timeout_q   <= 1'b0;
      frame_cnt_q <= '0;
      ctrl_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      tx_sel_q    <= tx_sel_d;
      last_sel_q  <= last_sel_d;
      timeout_q   <= timeout_d;
      frame_cnt_q <= frame_cnt_d;
      ctrl_cnt_q  <= ctrl_cnt_d;
    end
  end

  assign bus.tx_start = (state_q == S_START);
  assign bus.data_ack = (state_q == S_START) & ~tx_sel_q;
  assign bus.ctrl_ack = (state_q == S_START) &  tx_sel_q;
  assign bus.tx_sel   = tx_sel_q;
  assign sched_busy   = (state_q != S_IDLE);
  assign timeout_err  = timeout_q;
  assign frame_cnt    = frame_cnt_q;
  assign ctrl_cnt     = ctrl_cnt_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed + randomized bench for tx_frame_scheduler against a transaction-level reference model.
module tb_tx_frame_scheduler;
  localparam int IFG = 24;
  localparam int MW  = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          sched_busy;
  logic          timeout_err;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] ctrl_cnt;

  tx_frame_scheduler_if bus ();

  tx_frame_scheduler #(.IFG_NIBBLES(IFG), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .phy_txclk  (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus.master),
    .sched_busy (sched_busy),
    .timeout_err(timeout_err),
    .frame_cnt  (frame_cnt),
    .ctrl_cnt   (ctrl_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: request levels, last granted source, expected totals.
  bit last_ctrl;
  bit held_d, held_c;
  bit cur_sel;
  bit exp_t;
  int exp_f, exp_c;

  bit r_d, r_c;
  int r_dly, r_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_f % (1 << CW)));
    chk({tag, "_ctrl_cnt"}, 32'(ctrl_cnt), 32'(exp_c % (1 << CW)));
    chk({tag, "_timeout"}, 32'(timeout_err), 32'(exp_t));
  endtask

  task automatic model_reset();
    last_ctrl = 1'b1;
    cur_sel   = 1'b0;
    exp_t     = 1'b0;
    exp_f     = 0;
    exp_c     = 0;
  endtask

  // Raise requests (on top of any still held), expect a grant on the next edge.
  task automatic grant(input bit d, input bit c);
    held_d = held_d | d;
    held_c = held_c | c;
    bus.data_req = held_d;
    bus.ctrl_req = held_c;
`ifdef TX_SCHED_CTRL_PRIORITY_EN
    cur_sel = held_c;
`else
    cur_sel = (held_d && held_c) ? !last_ctrl : held_c;
`endif
    last_ctrl = cur_sel;
    tick();
    chk("grant_tx_start", 32'(bus.tx_start), 32'(1));
    chk("grant_tx_sel", 32'(bus.tx_sel), 32'(cur_sel));
    chk("grant_data_ack", 32'(bus.data_ack), 32'(!cur_sel));
    chk("grant_ctrl_ack", 32'(bus.ctrl_ack), 32'(cur_sel));
    chk("grant_busy", 32'(sched_busy), 32'(1));
    if (cur_sel) held_c = 1'b0;
    else held_d = 1'b0;
    bus.data_req = held_d;
    bus.ctrl_req = held_c;
  endtask

  // Transmit engine behaviour after tx_start: dly idle WAIT cycles, then len cycles of txen.
  task automatic body(input int dly, input int len, input bit en_drop);
    bit tmo;
    int t_end;
    tmo   = (dly >= MW - 1);
    t_end = tmo ? MW : dly + 2 + len;
    for (int e = 1; e <= t_end; e++) begin
      bus.phy_txen = !tmo && (e >= dly + 2) && (e <= dly + 1 + len);
      if (en_drop && e == t_end - 1) enable = 1'b0;
      tick();
      chk("frame_tx_start", 32'(bus.tx_start), 32'(0));
      chk("frame_busy", 32'(sched_busy), 32'(1));
      if (e == 1) begin
        chk("pulse_data_ack", 32'(bus.data_ack), 32'(0));
        chk("pulse_ctrl_ack", 32'(bus.ctrl_ack), 32'(0));
      end
      if (e == t_end) begin
        if (tmo) exp_t = 1'b1;
        else begin
          exp_f++;
          if (cur_sel) exp_c++;
        end
        chk_counts("frame_end");
      end else if (e == t_end - 1) begin
        chk_counts("frame_pre_end");
      end
    end
    for (int g = 1; g <= IFG; g++) begin
      bus.phy_txen = 1'($urandom_range(0, 1));
      tick();
      chk("gap_tx_start", 32'(bus.tx_start), 32'(0));
      chk("gap_busy", 32'(sched_busy), 32'(g < IFG));
      chk("gap_tx_sel", 32'(bus.tx_sel), 32'(cur_sel));
    end
    bus.phy_txen = 1'b0;
    if (en_drop) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        chk("disabled_tx_start", 32'(bus.tx_start), 32'(0));
        chk("disabled_busy", 32'(sched_busy), 32'(0));
      end
      enable = 1'b1;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(sched_busy), 32'(0));
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 32'(0));
    chk({tag, "_data_ack"}, 32'(bus.data_ack), 32'(0));
    chk({tag, "_ctrl_ack"}, 32'(bus.ctrl_ack), 32'(0));
    chk({tag, "_tx_sel"}, 32'(bus.tx_sel), 32'(0));
    chk_counts(tag);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    bus.data_req = 1'b0;
    bus.ctrl_req = 1'b0;
    bus.phy_txen = 1'b0;
    held_d = 1'b0;
    held_c = 1'b0;
    model_reset();
    tick();
    tick();
    chk_reset_state("reset");
    reset = 1'b0;
    tick();
    chk_reset_state("post_reset");

    // Single data frame: txen high 2 cycles after START, frame length 137.
    enable = 1'b1;
    grant(1'b1, 1'b0);
    body(2, 137, 1'b0);
    chk("single_frame_cnt", 32'(frame_cnt), 32'(1));

    // Engine never raises txen: sticky timeout, frame not counted.
    grant(1'b1, 1'b0);
    body(MW + 3, 0, 1'b0);
    chk("timeout_sticky", 32'(timeout_err), 32'(1));
    grant(1'b0, 1'b1);
    body(1, 5, 1'b0);

    // Enable drops mid-frame with a data request pending.
    grant(1'b1, 1'b0);
    held_d = 1'b1;
    bus.data_req = 1'b1;
    body(1, 10, 1'b1);
    grant(1'b0, 1'b0);
    body(0, 3, 1'b0);

    // Reset while ACTIVE, data request pending across reset.
    grant(1'b0, 1'b1);
    held_d = 1'b1;
    bus.data_req = 1'b1;
    bus.phy_txen = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    model_reset();
    chk_reset_state("mid_frame_reset");
    reset = 1'b0;
    bus.phy_txen = 1'b0;
    grant(1'b0, 1'b0);
    body(1, 3, 1'b0);

    // Both sources held continuously for four frames; start from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    held_d = 1'b0;
    held_c = 1'b0;
    bus.data_req = 1'b0;
    bus.ctrl_req = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) begin
      grant(1'b1, 1'b1);
      body(r, 4 + r, 1'b0);
    end
`ifndef TX_SCHED_CTRL_PRIORITY_EN
    chk("tie_frame_cnt", 32'(frame_cnt), 32'(4));
    chk("tie_ctrl_cnt", 32'(ctrl_cnt), 32'(2));
`endif

    // Randomized traffic, long enough to wrap the 4-bit counters.
    for (int i = 0; i < 24; i++) begin
      r_d = 1'($urandom_range(0, 1));
      r_c = 1'($urandom_range(0, 1));
      if (!(r_d | r_c | held_d | held_c)) r_d = 1'b1;
      r_dly = ($urandom_range(0, 9) == 0) ? MW - 1 + int'($urandom_range(0, 3))
                                          : int'($urandom_range(0, MW - 2));
      r_len = int'($urandom_range(1, 20));
      grant(r_d, r_c);
      body(r_dly, r_len, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/tx_frame_scheduler.md
Name: tx_frame_scheduler

Overview:
- Sequences the MII transmit engine and shares it between two frame sources: the data-frame buffer and the "need-data" control-frame request.
- Decides which frame goes next and issues a one-cycle start to the transmit engine.
- Watches phy_txen to track frame progress, then enforces the inter-frame gap before the next grant.
- Keeps frame counters and a sticky error flag for transmit-engine stalls.

Parameters:
IFG_NIBBLES, 24, inter-frame gap in phy_txclk cycles (96 bit times at 4 bits/cycle)
MAX_WAIT, 255, cycles allowed between tx_start and phy_txen rising before timeout
CNT_W, 16, width of frame counters

Ports:
phy_txclk  in  1  MII transmit clock; all logic on its negedge, matching the transmit engine
reset  in  1  synchronous, active-high
enable  in  1  allow new grants; frame in progress always completes
data_req  in  1  data frame ready; level, held until data_ack
ctrl_req  in  1  control (need-data) frame pending; level, held until ctrl_ack
data_ack  out  1  one-cycle pulse: data request accepted
ctrl_ack  out  1  one-cycle pulse: control request accepted
tx_start  out  1  one-cycle start pulse to transmit engine
tx_sel  out  1  0=data frame, 1=control frame; valid with tx_start, held until next grant
phy_txen  in  1  transmit-enable fed back from transmit engine
sched_busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky; set on MAX_WAIT expiry, cleared only by reset
frame_cnt  out  CNT_W  completed frames (both kinds)
ctrl_cnt  out  CNT_W  completed control frames

Behaviour:
- Reset values:
  - state IDLE
  - tx_start, data_ack, ctrl_ack, sched_busy, timeout_err, tx_sel all 0
  - counters 0
  - last_sel = 1, so data wins the first tie
- Outputs are decoded from registered state. No combinational path from any input to any output.
- States:
  - IDLE: if enable and (data_req or ctrl_req), go to START.
    - Only one requesting: grant it.
    - Both requesting: round-robin; grant the source not equal to last_sel.
    - On grant: load tx_sel and last_sel.
  - START (1 cycle): tx_start=1 and the matching ack=1. Clear the wait counter. Go to WAIT_TXEN.
  - WAIT_TXEN:
    - phy_txen=1: go to ACTIVE.
    - Otherwise increment the wait counter. When it reaches MAX_WAIT-1, set timeout_err, do not count the frame, and go to IFG.
  - ACTIVE: remain while phy_txen=1. On the first cycle phy_txen=0:
    - increment frame_cnt;
    - increment ctrl_cnt if tx_sel=1;
    - go to IFG with the gap counter cleared.
  - IFG: stay exactly IFG_NIBBLES cycles, then go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle N gives tx_start and ack at N+1.
  - If phy_txen is first sampled low at T: IFG covers T+1..T+IFG_NIBBLES, IDLE is at T+IFG_NIBBLES+1, and the earliest next tx_start is T+IFG_NIBBLES+2.
- A request dropped before its ack is simply not granted; no error.
- enable low: no grant from IDLE. All other states proceed normally.
- phy_txen high while in IDLE or IFG: ignored, no state change.
- Counters wrap from all-ones to 0 silently.
- Reset mid-frame: everything returns to reset values on the next edge. tx_start is never re-issued for the aborted frame.

Optional Feature:
TX_SCHED_CTRL_PRIORITY_EN
- Defined: ctrl_req has strict priority over data_req in IDLE, replacing round-robin. last_sel is still updated but not used for the decision.
- Undefined: round-robin as above.

Test Plan:
- Single data frame, IFG_NIBBLES=24:
  - stimulus: data_req high at cycle 10; phy_txen high cycles 14..150.
  - response: tx_start and data_ack pulse at cycle 11 with tx_sel=0; frame_cnt=1 after cycle 151; IDLE at cycle 176.
- Tie, two rounds:
  - stimulus: data_req and ctrl_req held high continuously.
  - response: grants go data, ctrl, data, ctrl; ctrl_cnt=2 and frame_cnt=4 after four frames; no tx_start inside any 24-cycle gap.
- Timeout, MAX_WAIT=8:
  - stimulus: grant a frame, keep phy_txen low.
  - response: timeout_err rises 8 cycles after tx_start, frame_cnt stays 0, scheduler returns to IDLE after the gap; timeout_err stays 1.
- enable low during ACTIVE with data_req pending:
  - response: current frame completes and is counted; no new tx_start until enable returns high.
- Reset during ACTIVE:
  - response: next edge shows state IDLE, all outputs 0, counters 0; a pending data_req is granted afresh after reset deasserts.
- With TX_SCHED_CTRL_PRIORITY_EN defined:
  - stimulus: both requests held.
  - response: ctrl is granted every round until ctrl_req drops.
